// File: rtl/arb_responder.sv
// arb_responder: common-bus arbiter responder for the micro-BESM CPU.
// Takes one operation per start strobe and runs it as a req/ack cycle on the
// memory bus: READ, WRITE, or a read-modify-write that ORs the held write
// data into the word just read. rdy (ARBRDY) is high only while idle.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   start, opc, addr,     operation issue from the microprogram
//   wdata
//   rdata, rdy, err       read data, idle/ready flag, last-op-failed flag
//   mem_req, mem_we,      bus request side
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata    bus response side
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for start; rdy=1
// RD      | read cycle, req high until ack or timeout
// WR      | write cycle of the held data
// RMW_RD  | read phase of RMW-OR
// RMW_GAP | one cycle with req low between RMW read and write
// RMW_WR  | write phase of RMW-OR, data = rdata | hold
module arb_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  opc,
  input  logic [31:0] addr,
  input  logic [71:0] wdata,
  output logic [71:0] rdata,
  output logic        rdy,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [71:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [71:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    RMW_RD  = 3'd3,
    RMW_GAP = 3'd4,
    RMW_WR  = 3'd5
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [71:0] hold;
  logic        accept;
  logic        rd_done;
  logic        timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    accept      = 1'b0;
    rd_done     = 1'b0;
    timeout_hit = 1'b0;
    rdy         = (state == IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          case (opc)
            4'd1:    state_nxt = RD;
            4'd2:    state_nxt = WR;
            4'd3:    state_nxt = RMW_RD;
            default: state_nxt = IDLE;
          endcase
        end
      end
      RD, RMW_RD: begin
        mem_req = 1'b1;
        // The read phase either completes on ack or aborts; an aborted RMW
        // read goes straight home so no write is issued.
        timeout_hit = !mem_ack && (cnt == TO_LIMIT);
        if (mem_ack) begin
          rd_done   = 1'b1;
          state_nxt = (state == RD) ? IDLE : RMW_GAP;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_wdata   = hold;
        timeout_hit = !mem_ack && (cnt == TO_LIMIT);
        if (mem_ack || timeout_hit) state_nxt = IDLE;
      end
      RMW_GAP: begin
        mem_wdata = rdata | hold;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_wdata   = rdata | hold;
        timeout_hit = !mem_ack && (cnt == TO_LIMIT);
        if (mem_ack || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      hold     <= '0;
      mem_addr <= '0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      if (accept) begin
        mem_addr <= addr;
        hold     <= wdata;
        cnt      <= '0;
        err      <= (opc > 4'd3);
      end else if (mem_req) begin
        if (mem_ack) begin
          cnt <= '0;
        end else if (timeout_hit) begin
          cnt   <= '0;
          err   <= 1'b1;
          rdata <= '1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      // rdata is left alone by the RMW write phase so it keeps the pre-OR word.
      if (rd_done) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_arb_responder.sv
module tb_arb_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opc = '0;
  logic [31:0] addr = '0;
  logic [71:0] wdata = '0;
  logic [71:0] rdata;
  logic        rdy, err, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [71:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [71:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  arb_responder #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opc(opc), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdy(rdy), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [71:0] d);
    start = 1'b1; opc = o; addr = a; wdata = d;
    step();
    start = 1'b0; opc = '0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%0b exp=1", rdy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    total++; if (rdata !== 72'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if ({mem_req, mem_we} !== 2'b00) begin bad++; $display("FAIL reset_req_we got=%b exp=00", {mem_req, mem_we}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 72'h0) begin bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    issue(4'd1, 32'h0000_1234, 72'h0);
    total++; if ({rdy, mem_req, mem_we} !== 3'b010) begin bad++; $display("FAIL read_issue rdy/req/we got=%b exp=010", {rdy, mem_req, mem_we}); end
    total++; if (mem_addr !== 32'h0000_1234) begin bad++; $display("FAIL read_addr got=%h exp=00001234", mem_addr); end
    step();
    step();
    total++; if ({rdy, mem_req, mem_addr} !== {2'b01, 32'h0000_1234}) begin bad++; $display("FAIL read_wait_stable got=%b/%b/%h", rdy, mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 72'hA5_0123456789ABCDEF;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if ({rdy, mem_req, err} !== 3'b100) begin bad++; $display("FAIL read_done rdy/req/err got=%b exp=100", {rdy, mem_req, err}); end
    total++; if (rdata !== 72'hA5_0123456789ABCDEF) begin bad++; $display("FAIL read_data got=%h exp=a50123456789abcdef", rdata); end
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 72'h11_2222222222222222;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if (rdata !== 72'hA5_0123456789ABCDEF || rdy !== 1'b1) begin bad++; $display("FAIL ack_idle got rdata=%h rdy=%b exp=a50123456789abcdef/1", rdata, rdy); end
  endtask

  task automatic test_write();
    issue(4'd2, 32'h0000_0ABC, 72'h0F_FFFF00000000FFFF);
    total++; if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 72'h0F_FFFF00000000FFFF) begin bad++; $display("FAIL write_bus got req/we=%b wdata=%h exp=11/0fffff00000000ffff", {mem_req, mem_we}, mem_wdata); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if ({rdy, mem_req, err} !== 3'b100) begin bad++; $display("FAIL write_done rdy/req/err got=%b exp=100", {rdy, mem_req, err}); end
  endtask

  task automatic test_rmw();
    issue(4'd3, 32'h0000_0040, 72'h00_0000000000000001);
    total++; if ({rdy, mem_req, mem_we} !== 3'b010) begin bad++; $display("FAIL rmw_rd rdy/req/we got=%b exp=010", {rdy, mem_req, mem_we}); end
    mem_ack = 1'b1; mem_rdata = 72'h80_8000000000000000;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if ({rdy, mem_req} !== 2'b00) begin bad++; $display("FAIL rmw_gap rdy/req got=%b exp=00", {rdy, mem_req}); end
    total++; if (mem_wdata !== 72'h80_8000000000000001) begin bad++; $display("FAIL rmw_gap_wdata got=%h exp=808000000000000001", mem_wdata); end
    step();
    total++; if ({rdy, mem_req, mem_we} !== 3'b011 || mem_wdata !== 72'h80_8000000000000001) begin bad++; $display("FAIL rmw_wr got=%b wdata=%h exp=011/808000000000000001", {rdy, mem_req, mem_we}, mem_wdata); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if ({rdy, mem_req, err} !== 3'b100) begin bad++; $display("FAIL rmw_done rdy/req/err got=%b exp=100", {rdy, mem_req, err}); end
    total++; if (rdata !== 72'h80_8000000000000000) begin bad++; $display("FAIL rmw_rdata got=%h exp=808000000000000000", rdata); end
  endtask

  task automatic test_timeout();
    int n;
    issue(4'd1, 32'h0000_0100, 72'h0);
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      step();
    end
    total++; if (n != 5) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=5", n); end
    total++; if ({rdy, err} !== 2'b11) begin bad++; $display("FAIL timeout_flags rdy/err got=%b exp=11", {rdy, err}); end
    total++; if (rdata !== {72{1'b1}}) begin bad++; $display("FAIL timeout_rdata got=%h exp=all ones", rdata); end
    issue(4'd1, 32'h0000_0200, 72'h0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_err_clear got=%b exp=0", err); end
    mem_ack = 1'b1; mem_rdata = 72'h01_0000000000000002;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if ({rdy, err} !== 2'b10 || rdata !== 72'h01_0000000000000002) begin bad++; $display("FAIL timeout_recover got=%b rdata=%h exp=10/010000000000000002", {rdy, err}, rdata); end
  endtask

  task automatic test_rmw_timeout();
    int n;
    issue(4'd3, 32'h0000_0300, 72'h00_00000000000000FF);
    n = 0;
    while ((mem_req === 1'b1 || rdy === 1'b0) && n < 30) begin
      if (mem_req === 1'b1) n++;
      step();
    end
    total++; if (n != 5) begin bad++; $display("FAIL rmw_timeout_req_cycles got=%0d exp=5", n); end
    total++; if ({rdy, err} !== 2'b11) begin bad++; $display("FAIL rmw_timeout_flags got=%b exp=11", {rdy, err}); end
  endtask

  task automatic test_illegal();
    int req_seen;
    issue(4'd7, 32'h0000_0700, 72'h0);
    total++; if ({rdy, err, mem_req} !== 3'b110) begin bad++; $display("FAIL illegal_flags rdy/err/req got=%b exp=110", {rdy, err, mem_req}); end
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req !== 1'b0) req_seen++;
      step();
    end
    total++; if (req_seen != 0 || rdy !== 1'b1) begin bad++; $display("FAIL illegal_no_bus req_cycles=%0d rdy=%b exp=0/1", req_seen, rdy); end
    issue(4'd0, 32'h0, 72'h0);
    total++; if ({rdy, err, mem_req} !== 3'b100) begin bad++; $display("FAIL nop_flags rdy/err/req got=%b exp=100", {rdy, err, mem_req}); end
  endtask

  task automatic test_back_to_back();
    int rises;
    logic prev;
    issue(4'd1, 32'h0000_AAAA, 72'h0);
    start = 1'b1; opc = 4'd2; addr = 32'h0000_BBBB; wdata = 72'h55;
    step();
    start = 1'b0; opc = '0; addr = '0; wdata = '0;
    total++; if (mem_addr !== 32'h0000_AAAA || mem_we !== 1'b0) begin bad++; $display("FAIL busy_start_ignored addr=%h we=%b exp=0000aaaa/0", mem_addr, mem_we); end
    // start coincides with the completion ack edge: must not be accepted
    mem_ack = 1'b1; mem_rdata = 72'h33;
    start = 1'b1; opc = 4'd2; addr = 32'h0000_CCCC;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    start = 1'b0; opc = '0; addr = '0;
    rises = 0; prev = mem_req;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1 && prev !== 1'b1) rises++;
      prev = mem_req;
      step();
    end
    total++; if (rises != 0 || rdy !== 1'b1 || rdata !== 72'h33) begin bad++; $display("FAIL completion_edge_start rises=%0d rdy=%b rdata=%h exp=0/1/33", rises, rdy, rdata); end
    issue(4'd1, 32'h0000_DDDD, 72'h0);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_DDDD) begin bad++; $display("FAIL start_after_idle req=%b addr=%h exp=1/0000dddd", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 72'h44;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset_mid_wr();
    issue(4'd2, 32'h0000_0900, 72'h12);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midwr_req got=%b exp=1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({rdy, mem_req, err} !== 3'b100 || rdata !== 72'h0 || mem_addr !== 32'h0) begin bad++; $display("FAIL async_reset rdy/req/err=%b rdata=%h addr=%h exp=100/0/0", {rdy, mem_req, err}, rdata, mem_addr); end
    step();
    reset_n = 1'b1;
    step();
    issue(4'd1, 32'h0000_0A00, 72'h0);
    mem_ack = 1'b1; mem_rdata = 72'h77_0000000000000077;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if ({rdy, err} !== 2'b10 || rdata !== 72'h77_0000000000000077) begin bad++; $display("FAIL post_reset_read got=%b rdata=%h exp=10/770000000000000077", {rdy, err}, rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_ack_idle();
    test_write();
    test_rmw();
    test_timeout();
    test_rmw_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
